// File: rtl/load_store_unit.sv
// Load/store unit: effective address, alignment and funct3 checks, req/ack data bus
// with byte strobes, sign/zero-extended load writeback and core stall.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   ld_en, st_en        request strobes (sampled in IDLE)
//   funct3              access width / signedness
//   base_addr, offset   effective address operands
//   store_data, rd_in   store source and load destination
//   stall               core must hold its instruction
//   wb_valid/wb_rd/wb_data  load writeback (one-cycle pulse)
//   misalign, illegal, bus_err  one-cycle fault pulses
//   mem_*               data-memory req/ack bus
module load_store_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] base_addr,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        illegal,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_load;
  logic [2:0]      r_f3;
  logic [1:0]      r_lane;

  logic [31:0] w_ea;
  logic        w_req;
  logic        w_both;
  logic        w_bad_f3;
  logic        w_mis;
  logic        w_go;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  assign w_ea   = base_addr + offset;
  assign w_req  = ld_en | st_en;
  assign w_both = ld_en & st_en;

  // Loads allow 000/001/010/100/101; stores only 000/001/010.
  assign w_bad_f3 = ld_en
    ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
    : (funct3[2] || (funct3[1:0] == 2'b11));

  assign w_mis = ((funct3[1:0] == 2'b01) && w_ea[0])
              || ((funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));

  assign w_go = (r_state == S_IDLE) && w_req
             && !w_both && !w_bad_f3 && !w_mis;

  // Gated by reset so every output reads 0 while reset is held.
  assign stall = !reset && ((r_state == S_WAIT) || w_go);

  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = 32'h0;
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        w_strb  = 4'b0001 << w_ea[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      (funct3[1:0] == 2'b01): begin
        w_strb  = w_ea[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  assign w_shift = mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_ext = w_shift;
    unique case (1'b1)
      (r_f3 == 3'b000): w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      (r_f3 == 3'b001): w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      (r_f3 == 3'b100): w_ext = {24'h0, w_shift[7:0]};
      (r_f3 == 3'b101): w_ext = {16'h0, w_shift[15:0]};
      default:          w_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_load <= 1'b0;
      r_f3      <= 3'b000;
      r_lane    <= 2'b00;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0;
      misalign  <= 1'b0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_both || w_bad_f3) begin
              illegal <= 1'b1;
            end else if (w_mis) begin
              misalign <= 1'b1;
            end else begin
              r_state   <= S_WAIT;
              r_cnt     <= '0;
              r_is_load <= ld_en;
              r_f3      <= funct3;
              r_lane    <= w_ea[1:0];
              wb_rd     <= rd_in;
              mem_req   <= 1'b1;
              mem_we    <= st_en;
              mem_addr  <= {w_ea[31:2], 2'b00};
              mem_wstrb <= st_en ? w_strb : 4'b0000;
              mem_wdata <= st_en ? w_wdata : 32'h0;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_state   <= S_DONE;
            wb_valid  <= r_is_load;
            if (r_is_load) wb_data <= w_ext;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
          end else if (r_cnt == TMO) begin
            r_state   <= S_IDLE;
            bus_err   <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level reference
// model of address, strobe, replication and extension rules.
module tb_load_store_unit;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en, st_en;
  logic [2:0]  funct3;
  logic [31:0] base_addr, offset, store_data;
  logic [4:0]  rd_in;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign, illegal, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] obs_addr, obs_wdata, obs_wb;
  logic [3:0]  obs_strb;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
    .base_addr(base_addr), .offset(offset),
    .store_data(store_data), .rd_in(rd_in),
    .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .illegal(illegal),
    .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                        input logic [31:0] ea);
    int n, lane;
    logic [3:0] s;
    n = 1 << f3[1:0];
    lane = int'(ea[1:0]);
    s = 4'b0000;
    for (int i = 0; i < 4; i++)
      s[i] = (i >= lane) && (i < lane + n);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] sd);
    int n;
    logic [31:0] w;
    n = 1 << f3[1:0];
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] ea,
                                         input logic [31:0] rw);
    int n, lane;
    longint v;
    n = 1 << f3[1:0];
    lane = int'(ea[1:0]);
    v = 0;
    for (int j = 0; j < n; j++)
      v = v | (longint'(rw[8*(lane + j) +: 8]) << (8 * j));
    if (!f3[2] && n < 4 && v[8*n-1])
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic do_access(input bit ld, input bit st,
                           input logic [2:0] f3,
                           input logic [31:0] base,
                           input logic [31:0] off,
                           input logic [31:0] sd,
                           input logic [4:0] rd,
                           input int dly,
                           input logic [31:0] rdat);
    logic [31:0] ea;
    int n, cnt;
    bit legal, mis, go, stable;
    logic [3:0] es;
    ea = base + off;
    n = 1 << f3[1:0];
    if (ld && st) legal = 0;
    else if (ld) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else legal = (f3 inside {3'd0, 3'd1, 3'd2});
    mis = legal && ((ea % n) != 0);
    go = (ld || st) && legal && !mis;
    es = st ? m_strb(f3, ea) : 4'b0000;

    @(negedge clk);
    ld_en = ld; st_en = st; funct3 = f3;
    base_addr = base; offset = off;
    store_data = sd; rd_in = rd;
    mem_ack = 1'($urandom % 2);
    #1 chk("stall_acc", stall, go);
    @(negedge clk);
    ld_en = 0; st_en = 0; mem_ack = 0;
    base_addr = $urandom; offset = $urandom;
    store_data = $urandom; funct3 = 3'($urandom);
    rd_in = 5'($urandom);
    if (!go) begin
      if (ld || st)
        chk("fault", {illegal, misalign, bus_err, mem_req, stall},
            {!legal, mis, 3'b000});
      @(negedge clk);
      chk("fault_clr", {illegal, misalign, mem_req, stall}, 0);
      return;
    end

    chk("req", {mem_req, mem_we, stall}, {1'b1, st, 1'b1});
    chk("addr", mem_addr, {ea[31:2], 2'b00});
    chk("strb", mem_wstrb, es);
    if (st) chk("wdata", mem_wdata, m_wdata(f3, sd));
    obs_addr = mem_addr;
    obs_strb = mem_wstrb;
    obs_wdata = mem_wdata;

    if (dly < 0) begin
      cnt = 1;
      while (cnt < TO + 10) begin
        @(negedge clk);
        if (!mem_req) break;
        cnt++;
      end
      chk("to_len", cnt, TO);
      chk("bus_err", {bus_err, wb_valid, stall}, 3'b100);
      @(negedge clk);
      chk("bus_err_clr", {bus_err, wb_valid, mem_req}, 0);
      return;
    end

    stable = 1;
    repeat (dly) begin
      @(negedge clk);
      if ({mem_req, mem_we, mem_addr, mem_wstrb, stall} !==
          {1'b1, st, obs_addr, obs_strb, 1'b1})
        stable = 0;
      if (st && mem_wdata !== obs_wdata) stable = 0;
    end
    chk("hold", stable, 1);
    mem_ack = 1; mem_rdata = rdat;
    @(negedge clk);
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    chk("done", {wb_valid, mem_req, stall}, {ld, 2'b00});
    if (ld) begin
      chk("wb_data", wb_data, m_load(f3, ea, rdat));
      chk("wb_rd", wb_rd, rd);
    end
    obs_wb = wb_data;
    @(negedge clk);
    mem_ack = 0;
    chk("wb_pulse", {wb_valid, mem_req}, 0);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    ld_en = 1; funct3 = 3'b010;
    base_addr = 32'h3000; offset = 32'h4; rd_in = 5'd7;
    @(negedge clk);
    ld_en = 0;
    chk("rst_pre_req", mem_req, 1);
    @(negedge clk);
    #2 reset = 1;
    #1 chk("rst_async", {mem_req, stall, wb_valid, illegal,
                         misalign, bus_err, mem_we}, 0);
    chk("rst_bus", {mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_data}, 0);
    @(negedge clk);
    reset = 0;
    mem_ack = 1; mem_rdata = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_wb", {wb_valid, mem_req, stall}, 0);
    end
    mem_ack = 0;
  endtask

  initial begin
    logic [2:0] ldf [5];
    logic [2:0] f3;
    logic [31:0] off;
    bit ld, st;
    int r, dly;
    ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1;
    ld_en = 1; st_en = 0; funct3 = 3'b010;
    base_addr = 0; offset = 0; store_data = 0; rd_in = 0;
    mem_ack = 0; mem_rdata = 0;
    #1 chk("rst_stall", stall, 0);
    @(negedge clk);
    chk("rst_out", {stall, wb_valid, wb_rd, wb_data, misalign,
                    illegal, bus_err, mem_req, mem_we}, 0);
    chk("rst_bus", {mem_addr, mem_wstrb, mem_wdata}, 0);
    ld_en = 0;
    reset = 0;

    do_access(0, 1, 3'b000, 32'h1000, 32'd3, 32'hAB, 5'd0, 2, 0);
    chk("sb_addr", obs_addr, 32'h1000);
    chk("sb_strb", obs_strb, 4'b1000);
    chk("sb_wdata", obs_wdata, 32'hABABABAB);

    do_access(1, 0, 3'b000, 32'h2000, 32'd2, 0, 5'd5, 1, 32'h80FF1234);
    chk("lb_data", obs_wb, 32'hFFFFFFFF);
    do_access(1, 0, 3'b100, 32'h2000, 32'd2, 0, 5'd5, 1, 32'h80FF1234);
    chk("lbu_data", obs_wb, 32'h000000FF);

    do_access(1, 0, 3'b010, 32'h2000, 32'd1, 0, 5'd1, 0, 0);
    do_access(1, 0, 3'b001, 32'h2000, 32'd3, 0, 5'd1, 0, 0);

    do_access(1, 0, 3'b010, 32'h4000, 32'd8, 0, 5'd9, -1, 0);
    do_access(1, 0, 3'b010, 32'h4000, 32'd8, 0, 5'd9, 2, 32'hCAFEF00D);
    chk("lw_after_to", obs_wb, 32'hCAFEF00D);

    reset_mid_wait();

    do_access(1, 1, 3'b010, 32'h5000, 32'd0, 0, 5'd2, 1, 0);
    do_access(1, 0, 3'b101, 32'h0, 32'hFFFFFFFE, 0, 5'd3, 1,
              32'h80FF1234);
    chk("lhu_addr", obs_addr, 32'hFFFFFFFC);
    chk("lhu_strb", obs_strb, 4'b0000);
    chk("lhu_data", obs_wb, 32'h000080FF);
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 5'd0, 0, 32'h55AA55AA);
    do_access(0, 1, 3'b011, 32'h100, 32'h0, 0, 5'd0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom % 16;
      ld = (r == 0) || (r >= 8);
      st = (r == 0) || (r >= 2 && r < 8);
      if ($urandom % 4 == 0) f3 = 3'($urandom);
      else if (ld) f3 = ldf[$urandom % 5];
      else f3 = 3'($urandom % 3);
      if ($urandom % 2 == 0) off = 32'($urandom_range(0, 15)) - 32'd8;
      else off = $urandom;
      dly = ($urandom % 40 == 0) ? -1 : int'($urandom_range(0, 5));
      do_access(ld, st, f3, $urandom, off, $urandom, 5'($urandom),
                dly, $urandom);
      if ($urandom % 3 == 0) begin
        @(negedge clk);
        mem_ack = 1'($urandom % 2);
        @(negedge clk);
        chk("idle_ack", {mem_req, wb_valid, stall}, 0);
        mem_ack = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
